// File: rtl/checkbits_pkg.sv
// Shared definitions for the checkbits monitor.
// Contents: phase code constants, FSM state enum, verdict/error enum and
// code-space helper functions.
package checkbits_pkg;

  // Phase codes on mprj_io[31:16]: 0xA0n0 start, 0xABn0 fail, 0xABn1 pass
  localparam logic [15:0] START_W = 16'hA040;
  localparam logic [15:0] START_S = 16'hA020;
  localparam logic [15:0] START_B = 16'hA010;
  localparam logic [15:0] FAIL_W  = 16'hAB40;
  localparam logic [15:0] FAIL_S  = 16'hAB20;
  localparam logic [15:0] FAIL_B  = 16'hAB10;
  localparam logic [15:0] PASS_W  = 16'hAB41;
  localparam logic [15:0] PASS_S  = 16'hAB21;
  localparam logic [15:0] PASS_B  = 16'hAB11;

  // Timeout shares ST_FAILED; err_code tells it apart from a phase/protocol fail.
  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN_W, ST_WAIT_S, ST_RUN_S,
    ST_WAIT_B, ST_RUN_B, ST_PASSED, ST_FAILED
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_PHASE, ERR_PROTO, ERR_TIMEOUT
  } err_e;

  // Codes outside 0xA0x0 / 0xABxx are not ours and are ignored.
  function automatic logic in_space(input logic [15:0] code);
    return ((code[15:8] == 8'hA0) && (code[3:0] == 4'h0)) || (code[15:8] == 8'hAB);
  endfunction

  function automatic logic is_terminal(input state_e s);
    return (s == ST_PASSED) || (s == ST_FAILED);
  endfunction

endpackage

// File: rtl/checkbits_filter.sv
// Synchronizer and stability filter for the raw checkbits bus.
// Ports:
//   clock, resetb  - clock, async active-low reset
//   checkbits      - raw 16-bit bus, asynchronous to clock
//   evt_valid      - 1-cycle pulse when a new stable value is accepted
//   evt_code       - last accepted value, held between pulses
module checkbits_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [15:0] checkbits,
  output logic        evt_valid,
  output logic [15:0] evt_code
);
  import checkbits_pkg::*;

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

  logic [15:0]   sync1_q, sync2_q, code_q;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          vld_q, accept;

  // sync1 != sync2 means sync2 changes on this edge, so restart the count.
  // cnt_d reaches STAB_MAX on the edge where sync2 has held STABLE_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    if (sync1_q != sync2_q)  cnt_d = '0;
    else if (cnt_q != STAB_MAX) cnt_d = cnt_q + 1'b1;
    // Comparing with the held code makes each value fire only once.
    accept = (cnt_d == STAB_MAX) && (sync2_q != code_q);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      sync1_q <= checkbits;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      vld_q   <= accept;
      if (accept) code_q <= sync2_q;
    end
  end

  assign evt_valid = vld_q;
  assign evt_code  = code_q;

endmodule

// File: rtl/mprj_checkbits_monitor.sv
// Monitor for the firmware mem-test status bus mprj_io[31:16].
// Filters the bus, walks word -> short -> byte phase codes, enforces order
// and a cycle timeout, and reports sticky done/pass/fail.
// Ports:
//   clock, resetb       - clock, async active-low reset
//   checkbits[15:0]     - raw status bus
//   enable              - timeout counter runs while high
//   evt_valid/evt_code  - accepted-code pulse and last accepted code
//   phase[1:0]          - 0 none, 1 word, 2 short, 3 byte
//   phases_passed[1:0]  - number of passed phases
//   done/pass/fail      - sticky verdict
//   err_code[1:0]       - 0 none, 1 phase fail, 2 protocol, 3 timeout
module mprj_checkbits_monitor #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 19
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [15:0] checkbits,
  input  logic        enable,
  output logic        evt_valid,
  output logic [15:0] evt_code,
  output logic [1:0]  phase,
  output logic [1:0]  phases_passed,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  err_code
);
  import checkbits_pkg::*;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, st_ev, st_d;
  err_e             err_q, err_ev, err_d;
  logic [1:0]       phase_q, phase_ev, passed_q, passed_ev;
  logic [CNT_W-1:0] tmo_q;
  logic             done_q, pass_q, fail_q, tmo_hit;

  checkbits_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clock     (clock),
    .resetb    (resetb),
    .checkbits (checkbits),
    .evt_valid (evt_valid),
    .evt_code  (evt_code)
  );

  // Event step first; timeout only applies if the event left us non-terminal.
  always_comb begin
    st_ev     = state_q;
    err_ev    = err_q;
    phase_ev  = phase_q;
    passed_ev = passed_q;
    if (evt_valid && in_space(evt_code) && !is_terminal(state_q)) begin
      // Anything not explicitly expected below is an order error.
      st_ev  = ST_FAILED;
      err_ev = ERR_PROTO;
      unique case (state_q)
        ST_IDLE:
          if (evt_code == START_W) begin st_ev = ST_RUN_W; err_ev = ERR_NONE; phase_ev = 2'd1; end
        ST_RUN_W:
          if (evt_code == PASS_W)      begin st_ev = ST_WAIT_S; err_ev = ERR_NONE; passed_ev = 2'd1; end
          else if (evt_code == FAIL_W) err_ev = ERR_PHASE;
        ST_WAIT_S:
          if (evt_code == START_S) begin st_ev = ST_RUN_S; err_ev = ERR_NONE; phase_ev = 2'd2; end
        ST_RUN_S:
          if (evt_code == PASS_S)      begin st_ev = ST_WAIT_B; err_ev = ERR_NONE; passed_ev = 2'd2; end
          else if (evt_code == FAIL_S) err_ev = ERR_PHASE;
        ST_WAIT_B:
          if (evt_code == START_B) begin st_ev = ST_RUN_B; err_ev = ERR_NONE; phase_ev = 2'd3; end
        ST_RUN_B:
          if (evt_code == PASS_B)      begin st_ev = ST_PASSED; err_ev = ERR_NONE; passed_ev = 2'd3; end
          else if (evt_code == FAIL_B) err_ev = ERR_PHASE;
        default: ;
      endcase
    end

    tmo_hit = enable && !is_terminal(state_q) && (tmo_q == TMO_LAST);
    st_d    = st_ev;
    err_d   = err_ev;
    if (tmo_hit && !is_terminal(st_ev)) begin
      st_d  = ST_FAILED;
      err_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      err_q    <= ERR_NONE;
      phase_q  <= 2'd0;
      passed_q <= 2'd0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= st_d;
      err_q    <= err_d;
      phase_q  <= phase_ev;
      passed_q <= passed_ev;
      done_q   <= is_terminal(st_d);
      pass_q   <= (st_d == ST_PASSED);
      fail_q   <= (st_d == ST_FAILED);
      // Saturating; enable low freezes without clearing.
      if (enable && !is_terminal(state_q) && (tmo_q != '1))
        tmo_q <= tmo_q + 1'b1;
    end
  end

  assign phase         = phase_q;
  assign phases_passed = passed_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign err_code      = err_q;

endmodule
